// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Common data bus arbiter for the Tomasulo back end. Each
//             functional unit owns a one-entry result buffer. One buffered
//             result per cycle is picked round-robin and broadcast on a
//             registered CDB that feeds RS snoop/forward logic and the
//             ROB/register-status writeback.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          clock, synchronous active-low reset
//    stall_i           global stall, freezes arbitration (no grant)
//    flush_i           kill all results belonging to thread flush_tid_i
//    flush_tid_i       thread being flushed
//    req_valid_i       per-requester result valid
//    req_ready_o       per-requester buffer can accept this cycle
//    req_tag_i         packed tags,   requester i at [i*TAG_W  +: TAG_W]
//    req_value_i       packed values, requester i at [i*DATA_W +: DATA_W]
//    req_tid_i         packed tids,   requester i at [i*TID_W  +: TID_W]
//    cdb_valid_o       registered broadcast valid
//    cdb_tag_o         registered broadcast tag
//    cdb_value_o       registered broadcast value
//    cdb_tid_o         registered broadcast thread ID
//    grant_o           one-hot (or zero) buffer granted this cycle
// ----------------------------------------------------------------------------
//  Build option
//    CDB_ARB_PRIORITY_EN : requester 0 (load unit) gets fixed absolute
//                          priority; the others share round-robin.
// ============================================================================
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int TID_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic [TID_W-1:0]        flush_tid_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*TAG_W-1:0]  req_tag_i,
  input  logic [N_REQ*DATA_W-1:0] req_value_i,
  input  logic [N_REQ*TID_W-1:0]  req_tid_i,
  output logic                    cdb_valid_o,
  output logic [TAG_W-1:0]        cdb_tag_o,
  output logic [DATA_W-1:0]       cdb_value_o,
  output logic [TID_W-1:0]        cdb_tid_o,
  output logic [N_REQ-1:0]        grant_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Result buffers
  logic [N_REQ-1:0]  buf_valid;
  logic [TAG_W-1:0]  buf_tag   [N_REQ];
  logic [DATA_W-1:0] buf_value [N_REQ];
  logic [TID_W-1:0]  buf_tid   [N_REQ];

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_next;
  logic              rr_adv;

  logic [N_REQ-1:0]  grant;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  int                scan_idx;
  logic              cdb_load;

  // --------------------------------------------------------------------------
  // Arbitration: first valid buffer at or above rr_ptr, wrapping around.
  // In priority mode the scan only runs when buffer 0 is empty, so the scan
  // naturally covers just requesters 1..N_REQ-1.
  // --------------------------------------------------------------------------
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    if (!stall_i) begin
`ifdef CDB_ARB_PRIORITY_EN
      if (buf_valid[0]) begin
        grant_any = 1'b1;
      end else
`endif
      begin
        for (int k = 0; k < N_REQ; k++) begin
          scan_idx = int'(rr_ptr) + k;
          if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
          if (!grant_any && buf_valid[PTR_W'(scan_idx)]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'(scan_idx);
          end
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
  end

  // Pointer moves past the winner. A priority grant to requester 0 must not
  // disturb the fairness order among the others.
  always_comb begin
    if (grant_idx == PTR_W'(N_REQ - 1)) rr_next = '0;
    else                                rr_next = grant_idx + 1'b1;
`ifdef CDB_ARB_PRIORITY_EN
    rr_adv = grant_any && (grant_idx != '0);
`else
    rr_adv = grant_any;
`endif
  end

  // A granted entry of the flushed thread is consumed but not broadcast.
  assign cdb_load = grant_any && !(flush_i && (buf_tid[grant_idx] == flush_tid_i));

  // A granted buffer frees up at this edge, so it can be refilled in the
  // same cycle for back-to-back throughput.
  assign req_ready_o = ~buf_valid | grant;
  assign grant_o     = grant;

  // --------------------------------------------------------------------------
  // State: pointer, CDB register, buffers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr      <= '0;
      buf_valid   <= '0;
      cdb_valid_o <= 1'b0;
      cdb_tag_o   <= '0;
      cdb_value_o <= '0;
      cdb_tid_o   <= '0;
    end else begin
      if (rr_adv) rr_ptr <= rr_next;

      // Data holds its last broadcast value whenever nothing is sent.
      cdb_valid_o <= cdb_load;
      if (cdb_load) begin
        cdb_tag_o   <= buf_tag[grant_idx];
        cdb_value_o <= buf_value[grant_idx];
        cdb_tid_o   <= buf_tid[grant_idx];
      end

      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid_i[i] && req_ready_o[i]) begin
          // Handshake completes normally; a flushed-thread arrival is simply
          // not kept.
          buf_valid[i] <= !(flush_i && (req_tid_i[i*TID_W +: TID_W] == flush_tid_i));
          buf_tag[i]   <= req_tag_i[i*TAG_W +: TAG_W];
          buf_value[i] <= req_value_i[i*DATA_W +: DATA_W];
          buf_tid[i]   <= req_tid_i[i*TID_W +: TID_W];
        end else if (grant[i] || (flush_i && (buf_tid[i] == flush_tid_i))) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter (N_REQ=4, TAG_W=4,
//             DATA_W=32, TID_W=1). Per-cycle vectors carry inputs plus the
//             expected ready/grant and broadcast; expected broadcasts go to a
//             scoreboard queue and are popped when the CDB shows valid.
//             Honors CDB_ARB_PRIORITY_EN for the priority-dependent rows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam int IW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall_i, flush_i;
  logic [IW-1:0]   flush_tid_i;
  logic [N-1:0]    req_valid_i, req_ready_o, grant_o;
  logic [N*TW-1:0] req_tag_i;
  logic [N*DW-1:0] req_value_i;
  logic [N*IW-1:0] req_tid_i;
  logic            cdb_valid_o;
  logic [TW-1:0]   cdb_tag_o;
  logic [DW-1:0]   cdb_value_o;
  logic [IW-1:0]   cdb_tid_o;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW), .TID_W(IW)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .flush_tid_i(flush_tid_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o), .req_tag_i(req_tag_i),
    .req_value_i(req_value_i), .req_tid_i(req_tid_i),
    .cdb_valid_o(cdb_valid_o), .cdb_tag_o(cdb_tag_o),
    .cdb_value_o(cdb_value_o), .cdb_tid_o(cdb_tid_o), .grant_o(grant_o)
  );

  typedef struct {
    logic        rst_n, stall, flush, ftid;
    logic [3:0]  valid;
    logic [15:0] tags;
    logic [3:0]  tids;
    logic [3:0]  exp_ready, exp_grant;
    logic        exp_cv;
    logic [3:0]  exp_tag;
    logic        exp_tid;
  } vec_t;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] value;
    logic        tid;
  } bc_t;

  vec_t vecs[$];
  bc_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] val_of(input logic [3:0] t);
    return 32'h0000_00A9 ^ {28'h0, t};
  endfunction

  task automatic add(input logic r, s, f, ft, input logic [3:0] v,
                     input logic [15:0] tg, input logic [3:0] td,
                     input logic [3:0] er, eg, input logic ecv,
                     input logic [3:0] et, input logic etid);
    vec_t x;
    x.rst_n = r; x.stall = s; x.flush = f; x.ftid = ft;
    x.valid = v; x.tags = tg; x.tids = td;
    x.exp_ready = er; x.exp_grant = eg; x.exp_cv = ecv;
    x.exp_tag = et; x.exp_tid = etid;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    rst         = x.rst_n;
    stall_i     = x.stall;
    flush_i     = x.flush;
    flush_tid_i = x.ftid;
    req_valid_i = x.valid;
    req_tag_i   = x.tags;
    req_tid_i   = x.tids;
    for (int i = 0; i < N; i++) req_value_i[i*DW +: DW] = val_of(x.tags[i*TW +: TW]);
  endtask

  // Called at posedge+1: apply, check combinational outputs mid-cycle, then
  // check the registered broadcast after the edge.
  task automatic run_vec(input vec_t x, input int n);
    bc_t e;
    drive(x);
    #3;
    check($sformatf("ready[%0d]", n), 32'(req_ready_o), 32'(x.exp_ready));
    check($sformatf("grant[%0d]", n), 32'(grant_o), 32'(x.exp_grant));
    if (x.exp_cv) begin
      e.tag = x.exp_tag; e.value = val_of(x.exp_tag); e.tid = x.exp_tid;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    check($sformatf("cdb_valid[%0d]", n), 32'(cdb_valid_o), 32'(x.exp_cv));
    if (cdb_valid_o) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bcast[%0d]: got tag %h expected none", n, cdb_tag_o);
      end else begin
        e = sb.pop_front();
        check($sformatf("cdb_tag[%0d]", n),   32'(cdb_tag_o),   32'(e.tag));
        check($sformatf("cdb_value[%0d]", n), cdb_value_o,      e.value);
        check($sformatf("cdb_tid[%0d]", n),   32'(cdb_tid_o),   32'(e.tid));
      end
    end
  endtask

  initial begin
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; flush_tid_i = '0;
    req_valid_i = '0; req_tag_i = '0; req_value_i = '0; req_tid_i = '0;

    //   rst s f ft valid    tags      tids     ready    grant   cv tag tid
    // single result, 2-cycle latency
    add(1, 0,0,0, 4'b0001, 16'h0003, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0001, 1, 3, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    add(0, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    // all four stream continuously for 8 cycles, then drain
    add(1, 0,0,0, 4'b1111, 16'h4321, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    add(1, 0,0,0, 4'b1111, 16'h4321, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0);
    add(1, 0,0,0, 4'b1111, 16'h4321, 4'b0000, 4'b0010, 4'b0010, 1, 2, 0);
    add(1, 0,0,0, 4'b1111, 16'h4321, 4'b0000, 4'b0100, 4'b0100, 1, 3, 0);
    add(1, 0,0,0, 4'b1111, 16'h4321, 4'b0000, 4'b1000, 4'b1000, 1, 4, 0);
    add(1, 0,0,0, 4'b1111, 16'h4321, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0);
    add(1, 0,0,0, 4'b1111, 16'h4321, 4'b0000, 4'b0010, 4'b0010, 1, 2, 0);
    add(1, 0,0,0, 4'b1111, 16'h4321, 4'b0000, 4'b0100, 4'b0100, 1, 3, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1000, 4'b1000, 1, 4, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1001, 4'b0001, 1, 1, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1011, 4'b0010, 1, 2, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0100, 1, 3, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    // stall with buffers 1,2 full (rr_ptr=3), then 1 before 2
    add(1, 0,0,0, 4'b0110, 16'h0650, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    add(1, 1,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1001, 4'b0000, 0, 0, 0);
    add(1, 1,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1001, 4'b0000, 0, 0, 0);
    add(1, 1,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1001, 4'b0000, 0, 0, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1011, 4'b0010, 1, 5, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0100, 1, 6, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    add(0, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    // flush: granted tid-1 entry dropped, tid-0 entry follows
    add(1, 0,0,0, 4'b0011, 16'h0098, 4'b0001, 4'b1111, 4'b0000, 0, 0, 0);
    add(1, 0,1,1, 4'b0000, 16'h0000, 4'b0000, 4'b1101, 4'b0001, 0, 0, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0010, 1, 9, 0);
    // arrival of flushed thread is discarded
    add(1, 0,1,1, 4'b0100, 16'h0A00, 4'b0100, 4'b1111, 4'b0000, 0, 0, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    // idle buffer of flushed thread killed while stalled
    add(1, 0,0,0, 4'b1000, 16'hB000, 4'b1000, 4'b1111, 4'b0000, 0, 0, 0);
    add(1, 1,1,1, 4'b0000, 16'h0000, 4'b0000, 4'b0111, 4'b0000, 0, 0, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    // flush of the other thread leaves a tid-1 entry alone (rr_ptr=2)
    add(1, 0,0,0, 4'b0001, 16'h000C, 4'b0001, 4'b1111, 4'b0000, 0, 0, 0);
    add(1, 0,1,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0001, 1, 4'hC, 1);
    add(0, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    // requesters 0 and 2 request continuously
    add(1, 0,0,0, 4'b0101, 16'h0D0C, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    add(1, 0,0,0, 4'b0101, 16'h0D0C, 4'b0000, 4'b1011, 4'b0001, 1, 4'hC, 0);
`ifdef CDB_ARB_PRIORITY_EN
    add(1, 0,0,0, 4'b0101, 16'h0D0C, 4'b0000, 4'b1011, 4'b0001, 1, 4'hC, 0);
    add(1, 0,0,0, 4'b0101, 16'h0D0C, 4'b0000, 4'b1011, 4'b0001, 1, 4'hC, 0);
    add(1, 0,0,0, 4'b0101, 16'h0D0C, 4'b0000, 4'b1011, 4'b0001, 1, 4'hC, 0);
`else
    add(1, 0,0,0, 4'b0101, 16'h0D0C, 4'b0000, 4'b1110, 4'b0100, 1, 4'hD, 0);
    add(1, 0,0,0, 4'b0101, 16'h0D0C, 4'b0000, 4'b1011, 4'b0001, 1, 4'hC, 0);
    add(1, 0,0,0, 4'b0101, 16'h0D0C, 4'b0000, 4'b1110, 4'b0100, 1, 4'hD, 0);
`endif
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1011, 4'b0001, 1, 4'hC, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0100, 1, 4'hD, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    // reset while all four buffers are full (rr_ptr=3)
    add(1, 0,0,0, 4'b1111, 16'h4321, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
`ifdef CDB_ARB_PRIORITY_EN
    add(0, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b0001, 4'b0001, 0, 0, 0);
`else
    add(0, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1000, 4'b1000, 0, 0, 0);
`endif
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    add(1, 0,0,0, 4'b0000, 16'h0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready_o), 32'hF);
    check("rst_grant", 32'(grant_o),     32'h0);
    check("rst_cv",    32'(cdb_valid_o), 32'h0);
    check("rst_tag",   32'(cdb_tag_o),   32'h0);
    check("rst_value", cdb_value_o,      32'h0);
    check("rst_tid",   32'(cdb_tid_o),   32'h0);

    for (int n = 0; n < vecs.size(); n++) run_vec(vecs[n], n);

    // The mid-operation reset must have cleared the broadcast data too
    check("post_rst_tag",   32'(cdb_tag_o),   32'h0);
    check("post_rst_value", cdb_value_o,      32'h0);
    check("post_rst_tid",   32'(cdb_tid_o),   32'h0);

    // Broadcast data holds after valid drops
    req_valid_i = 4'b0010; req_tag_i = 16'h0050; req_tid_i = 4'b0010;
    req_value_i = '0; req_value_i[1*DW +: DW] = val_of(4'h5);
    @(posedge clk); #1;
    req_valid_i = '0; req_tag_i = '0; req_tid_i = '0; req_value_i = '0;
    #3;
    check("hold_grant", 32'(grant_o), 32'h2);
    @(posedge clk); #1;
    check("hold_cv1",   32'(cdb_valid_o), 32'h1);
    check("hold_tag1",  32'(cdb_tag_o),   32'h5);
    check("hold_tid1",  32'(cdb_tid_o),   32'h1);
    @(posedge clk); #1;
    check("hold_cv0",   32'(cdb_valid_o), 32'h0);
    check("hold_tag0",  32'(cdb_tag_o),   32'h5);
    check("hold_value", cdb_value_o,      val_of(4'h5));
    check("hold_tid0",  32'(cdb_tid_o),   32'h1);

    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
